fp_div_seq: RTL
===============

# fp_div_seq

Sequential signed fixed-point divider, the inverse companion to the team's fixed-point multiplier. It takes a QWI1.WF1 dividend and a QWI2.WF2 divisor and returns a QWIO.WFO quotient using radix-2 restoring division, one quotient bit per cycle. Results carry the same overflow (saturated) and underflow (inexact, nonzero discarded remainder) flag semantics as the multiplier. Valid/ready handshakes on both sides let it sit in the fixed-point datapath between producer and consumer stages.

## Interface
- WI1, 5, dividend integer bits (incl. sign)
- WF1, 14, dividend fraction bits
- WI2, 5, divisor integer bits (incl. sign)
- WF2, 14, divisor fraction bits
- WIO, 10, quotient integer bits (incl. sign)
- WFO, 14, quotient fraction bits; WFO+WF2-WF1 >= 0 is a hard requirement (elaboration error otherwise)
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operands valid
- in_ready  out  1  divider idle, able to accept operands
- A  in  WI1+WF1  signed dividend
- B  in  WI2+WF2  signed divisor
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- quotient  out  WIO+WFO  signed, saturated quotient
- overflow  out  1  quotient saturated (includes divide-by-zero)
- underflow  out  1  nonzero remainder discarded (result inexact)
- div_by_zero  out  1  B was zero

## Operation
- Derived: SH = WFO+WF2-WF1; NW = WI1+WF1+SH (numerator/quotient magnitude width); WO = WIO+WFO.
- Accept: when in_valid && in_ready, register sign = A[msb]^B[msb], |A| zero-extended and shifted left by SH, |B|, and the B==0 and A==0 conditions.
- FSM states:
  - IDLE: in_ready=1. Accept goes to DZ if B==0, otherwise to DIV with counter = NW-1.
  - DIV: one restoring step per cycle (shift remainder, trial subtract, set quotient bit). Counter at 0 goes to FIX.
  - FIX: sign application, rounding (if enabled), saturation and flag computation; results are registered. Goes to DONE.
  - DZ: quotient = 0x7FF..F if A>=0 else 0x800..0; overflow=1; div_by_zero=1; underflow=0. Goes to DONE.
  - DONE: out_valid=1, all outputs held stable. out_ready goes to IDLE.
- Rounding: truncation toward zero (default).
- Saturation on positive sign: magnitude > 2^(WO-1)-1 gives 2^(WO-1)-1 with overflow=1.
- Saturation on negative sign: magnitude > 2^(WO-1) gives -2^(WO-1) with overflow=1.
- A==0 with B!=0: quotient 0, sign forced positive, no flags.
- Dividend -2^(msb) is handled: its magnitude is carried in full width.
- underflow = (final remainder != 0). Under saturation, underflow is still reported as computed.

## Timing
- Reset values: in_ready=1, out_valid=0, quotient=0, overflow=0, underflow=0, div_by_zero=0. FSM resets to IDLE.
- Latency from accept edge to out_valid:
  - NW+2 cycles for normal operands (35 at defaults).
  - 2 cycles for divide-by-zero.
- in_ready is high only in IDLE. Throughput is one op per NW+3 cycles minimum.
- in_valid outside IDLE is ignored. A is not sampled while busy; no queueing.
- out_valid stays high until out_ready; the result is held unchanged under backpressure.
- out_ready while out_valid=0 has no effect.
- Reset asserted mid-operation aborts immediately. The operation in flight is lost, with no partial output.

## Configuration
- FPDIV_ROUND_EN defined: round-to-nearest, ties away from zero. In FIX, magnitude += 1 when 2*remainder >= |B|, applied before saturation; rounding can itself cause overflow. underflow still means remainder != 0.
- FPDIV_ROUND_EN undefined: truncation toward zero. The rounding comparator is not built.

## Structure
- Package fp_div_pkg holds:
  - state_e enum (IDLE, DIV, FIX, DZ, DONE)
  - result flag struct (overflow, underflow, div_by_zero)
  - shared saturation helper functions
- Sub-module fp_div_sat: combinational sign application, optional rounding and saturation, used in FIX.
- Top fp_div_seq: FSM, iteration counter, remainder/quotient shift registers and handshakes.

## Test plan
- A=0x0C000 (3.0), B=0x06000 (1.5) -> quotient=0x008000 (2.0), all flags 0, out_valid exactly 35 cycles after accept.
- A=0x08000 (2.0), B=0x0C000 (3.0) -> 0x002AAA and underflow=1; with FPDIV_ROUND_EN -> 0x002AAB. Same with A=-2.0 (0x78000) -> 0xFFD556; rounded -> 0xFFD555.
- A=0x3FFFF, B=0x00001 -> quotient=0x7FFFFF, overflow=1. A=0x40000 (-16.0), B=0x00001 -> 0x800000, overflow=1.
- A=0x04000, B=0 -> 0x7FFFFF, overflow=1, div_by_zero=1, out_valid 2 cycles after accept. A=0x7C000 (-1.0), B=0 -> 0x800000.
- Backpressure: out_ready held low 5 cycles after out_valid -> outputs stable, in_ready=0, in_valid pulses ignored. Next op proceeds normally after release.
- rst_n low at DIV cycle 10 -> all outputs at reset values, in_ready=1. A following 3.0/1.5 returns 0x008000.

Source files
------------

// File: rtl/fp_div_pkg.sv
// Shared types and saturation helpers for the sequential fixed-point divider.
package fp_div_pkg;

    typedef enum logic [2:0] {IDLE, DIV, FIX, DZ, DONE} state_e;

    typedef struct packed {
        logic overflow;
        logic underflow;
        logic div_by_zero;
    } flags_t;

    // Largest positive magnitude representable in a wo-bit two's complement word.
    function automatic logic [63:0] sat_pos_lim(input int wo);
        return (64'd1 << (wo - 1)) - 64'd1;
    endfunction

    // Largest negative magnitude representable in a wo-bit two's complement word.
    function automatic logic [63:0] sat_neg_lim(input int wo);
        return 64'd1 << (wo - 1);
    endfunction

endpackage

// File: rtl/fp_div_sat.sv
// Final-stage result shaping: optional round-to-nearest (ties away from zero),
// sign application and saturation. Rounding is built only with FPDIV_ROUND_EN.
module fp_div_sat
    import fp_div_pkg::*;
#(
    parameter int NW = 33,
    parameter int WB = 19,
    parameter int WO = 24
) (
    input  logic          i_sign,
    input  logic [NW-1:0] i_mag,
    input  logic [WB-1:0] i_rem,
    input  logic [WB-1:0] i_bmag,
    output logic [WO-1:0] o_q,
    output logic          o_ovf,
    output logic          o_unf
);

    logic        w_up;
    logic [63:0] w_mag;

`ifdef FPDIV_ROUND_EN
    // 2*rem >= |B| means the discarded fraction is at least one half.
    assign w_up = ({i_rem, 1'b0} >= {1'b0, i_bmag});
`else
    logic w_unused_bmag;
    assign w_unused_bmag = ^i_bmag;
    assign w_up          = 1'b0;
`endif

    assign w_mag = 64'(i_mag) + 64'(w_up);

    // Clamp the (possibly rounded) magnitude to the signed output range.
    always_comb begin
        o_q   = '0;
        o_ovf = 1'b0;
        o_unf = (i_rem != '0);
        if (!i_sign) begin
            if (w_mag > sat_pos_lim(WO)) begin
                o_q   = WO'(sat_pos_lim(WO));
                o_ovf = 1'b1;
            end else begin
                o_q = w_mag[WO-1:0];
            end
        end else begin
            if (w_mag > sat_neg_lim(WO)) begin
                o_q   = WO'(sat_neg_lim(WO));
                o_ovf = 1'b1;
            end else begin
                o_q = ~w_mag[WO-1:0] + WO'(1);
            end
        end
    end

endmodule

// File: rtl/fp_div_seq.sv
// Sequential signed fixed-point divider, radix-2 restoring, one quotient bit
// per cycle. Optional rounding is enabled by defining FPDIV_ROUND_EN.
module fp_div_seq
    import fp_div_pkg::*;
#(
    parameter int WI1 = 5,
    parameter int WF1 = 14,
    parameter int WI2 = 5,
    parameter int WF2 = 14,
    parameter int WIO = 10,
    parameter int WFO = 14
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WI1+WF1-1:0]   A,
    input  logic [WI2+WF2-1:0]   B,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIO+WFO-1:0]   quotient,
    output logic                 overflow,
    output logic                 underflow,
    output logic                 div_by_zero
);

    localparam int SH = WFO + WF2 - WF1;
    localparam int WA = WI1 + WF1;
    localparam int WB = WI2 + WF2;
    localparam int NW = WA + SH;
    localparam int WO = WIO + WFO;
    localparam int CW = (NW > 1) ? $clog2(NW) : 1;

    if (SH < 0) begin : g_bad_shift
        $error("fp_div_seq: WFO+WF2-WF1 must be >= 0");
    end

    state_e        r_state, w_state_nx;
    logic [CW-1:0] r_cnt;
    logic          r_sign, r_azero;
    logic [WB-1:0] r_bmag, r_rem;
    logic [NW-1:0] r_q;          // numerator bits shift out the top, quotient bits in at the bottom
    logic [WO-1:0] r_quot;
    flags_t        r_flags;

    logic [WA-1:0] w_amag;
    logic [WB-1:0] w_bmag, w_rem_nx;
    logic [WB:0]   w_rem_sh, w_rem_diff;
    logic          w_ge, w_unused_msb;
    logic [WO-1:0] w_sat_q;
    logic          w_ovf, w_unf;

    // Magnitudes are unsigned so the most negative operand keeps its full value.
    assign w_amag       = A[WA-1] ? (~A + WA'(1)) : A;
    assign w_bmag       = B[WB-1] ? (~B + WB'(1)) : B;
    assign w_rem_sh     = {r_rem, r_q[NW-1]};
    assign w_rem_diff   = w_rem_sh - {1'b0, r_bmag};
    assign w_ge         = (w_rem_sh >= {1'b0, r_bmag});
    assign w_rem_nx     = w_ge ? w_rem_diff[WB-1:0] : w_rem_sh[WB-1:0];
    assign w_unused_msb = w_rem_diff[WB];

    fp_div_sat #(.NW(NW), .WB(WB), .WO(WO)) u_sat (
        .i_sign (r_sign & ~r_azero),
        .i_mag  (r_q),
        .i_rem  (r_rem),
        .i_bmag (r_bmag),
        .o_q    (w_sat_q),
        .o_ovf  (w_ovf),
        .o_unf  (w_unf)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nx;
    end

    // Next-state logic.
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            IDLE: if (in_valid) w_state_nx = (B == '0) ? DZ : DIV;
            DIV:  if (r_cnt == '0) w_state_nx = FIX;
            FIX:  w_state_nx = DONE;
            DZ:   w_state_nx = DONE;
            DONE: if (out_ready) w_state_nx = IDLE;
            default: w_state_nx = IDLE;
        endcase
    end

    // Operand capture, restoring iteration and result registration.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_sign  <= 1'b0;
            r_azero <= 1'b0;
            r_bmag  <= '0;
            r_rem   <= '0;
            r_q     <= '0;
            r_quot  <= '0;
            r_flags <= '0;
        end else begin
            case (r_state)
                IDLE: if (in_valid) begin
                    r_sign  <= A[WA-1] ^ B[WB-1];
                    r_azero <= (A == '0);
                    r_bmag  <= w_bmag;
                    r_rem   <= '0;
                    r_q     <= NW'(w_amag) << SH;
                    r_cnt   <= CW'(NW - 1);
                end
                DIV: begin
                    r_rem <= w_rem_nx;
                    r_q   <= {r_q[NW-2:0], w_ge};
                    r_cnt <= r_cnt - CW'(1);
                end
                FIX: begin
                    r_quot  <= w_sat_q;
                    r_flags <= '{overflow: w_ovf, underflow: w_unf, div_by_zero: 1'b0};
                end
                DZ: begin
                    // B is zero, so the captured sign is just the sign of A.
                    r_quot  <= r_sign ? WO'(sat_neg_lim(WO)) : WO'(sat_pos_lim(WO));
                    r_flags <= '{overflow: 1'b1, underflow: 1'b0, div_by_zero: 1'b1};
                end
                default: ;
            endcase
        end
    end

    assign in_ready    = (r_state == IDLE);
    assign out_valid   = (r_state == DONE);
    assign quotient    = r_quot;
    assign overflow    = r_flags.overflow;
    assign underflow   = r_flags.underflow;
    assign div_by_zero = r_flags.div_by_zero;

endmodule
